// File: rtl/inst_fetcher.sv
// inst_fetcher: single-outstanding instruction fetch front-end, optional 2-bit BHT under `BRANCH_PRED_EN`.
// Latency: accept -> next ins_ready = 2 cycles + memory latency; dec_stall holds the instruction, rdy_in=0 freezes all state.
module inst_fetcher #(
    parameter int          BHT_BITS = 6,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    output logic        ins_ready,
    output logic [31:0] ins,
    output logic [31:0] pc,
    output logic        pred_jump,
    input  logic        dec_stall,
    input  logic        dec_clear,
    input  logic [31:0] dec_new_addr,
    input  logic        rob_clear,
    input  logic [31:0] rob_new_addr,
    input  logic        br_upd_valid,
    input  logic [31:0] br_upd_pc,
    input  logic        br_upd_taken
);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic        drop;

    logic        redirect;
    logic [31:0] redirect_addr;
    logic        accept;
    logic [31:0] next_pc;
    logic        fetch_pred;

    assign redirect      = rob_clear | dec_clear;
    assign redirect_addr = rob_clear ? rob_new_addr : dec_new_addr;
    assign accept        = ins_ready & ~dec_stall;

`ifdef BRANCH_PRED_EN
    localparam int BHT_N = 2 ** BHT_BITS;

    logic [1:0]          bht [BHT_N];
    logic [BHT_BITS-1:0] upd_idx;
    logic [31:0]         b_imm;

    assign upd_idx    = br_upd_pc[BHT_BITS+1:2];
    // Prediction is sampled from the incoming word, so a same-cycle update is not yet visible.
    assign fetch_pred = (mem_data[6:0] == OP_BRANCH) & bht[mem_addr[BHT_BITS+1:2]][1];
    assign b_imm      = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    assign next_pc    = ((ins[6:0] == OP_BRANCH) && pred_jump) ? pc + b_imm : pc + 32'd4;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (rdy_in && br_upd_valid) begin
            if (br_upd_taken && bht[upd_idx] != 2'b11) begin
                bht[upd_idx] <= bht[upd_idx] + 2'd1;
            end else if (!br_upd_taken && bht[upd_idx] != 2'b00) begin
                bht[upd_idx] <= bht[upd_idx] - 2'd1;
            end
        end
    end
`else
    assign fetch_pred = 1'b0;
    assign next_pc    = pc + 32'd4;
`endif

    logic unused_upd;
    assign unused_upd = ^{br_upd_valid, br_upd_taken, br_upd_pc};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= 32'd0;
            ins_ready <= 1'b0;
            ins       <= 32'd0;
            pc        <= 32'd0;
            pred_jump <= 1'b0;
            fetch_pc  <= RESET_PC;
            drop      <= 1'b0;
        end else if (rdy_in) begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc <= redirect_addr;
                    end else begin
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_done) begin
                        mem_req <= 1'b0;
                    end
                    // A redirect before the data arrives leaves the request in flight, marked for discard.
                    if (redirect) begin
                        fetch_pc <= redirect_addr;
                        drop     <= ~mem_done;
                        if (mem_done) begin
                            state <= IDLE;
                        end
                    end else if (mem_done) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            ins       <= mem_data;
                            pc        <= mem_addr;
                            pred_jump <= fetch_pred;
                            ins_ready <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        fetch_pc  <= redirect_addr;
                        ins_ready <= 1'b0;
                        state     <= IDLE;
                    end else if (accept) begin
                        fetch_pc  <= next_pc;
                        ins_ready <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
